// File: rtl/audio_sample_processor.sv
// audio_sample_processor: per-sample stage between the codec ADC and DAC FIFOs.
// Each sample pair passes through four states: capture, route + noise, gain, write.
// Every stage saturates its result.
// Ports:
//   CLOCK2_50, reset        clock; asynchronous active-high reset
//   enable                  allow new captures
//   mode                    00 pass, 01 swap, 10 mono, 11 mute
//   noise_en, noise_shift   add per-channel LFSR noise, attenuated by an arithmetic shift
//   gain                    unsigned Q4.4 gain (0x10 = unity)
//   clip_clr                clear the sticky clip_flag
//   read_ready/write_ready  ADC FIFO non-empty / DAC FIFO non-full
//   readdata_left/right     ADC samples
//   read/write              one-cycle FIFO pop/push pulses
//   writedata_left/right    processed samples, held until the next sample
//   clip_flag               sticky saturation indicator
//   sample_count            completed samples, wraps
//   busy                    high outside IDLE
module audio_sample_processor #(
  parameter int unsigned DATA_WIDTH = 24,
  parameter logic [31:0] SEED_L     = 32'h005A_EC3D,
  parameter logic [31:0] SEED_R     = 32'h00C3_197B,
  parameter logic [31:0] TAPS_L     = 32'h000E_0002,
  parameter logic [31:0] TAPS_R     = 32'h000D_0008
) (
  input  logic                  CLOCK2_50,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [1:0]            mode,
  input  logic                  noise_en,
  input  logic [4:0]            noise_shift,
  input  logic [7:0]            gain,
  input  logic                  clip_clr,
  input  logic                  read_ready,
  input  logic                  write_ready,
  input  logic [DATA_WIDTH-1:0] readdata_left,
  input  logic [DATA_WIDTH-1:0] readdata_right,
  output logic                  read,
  output logic                  write,
  output logic [DATA_WIDTH-1:0] writedata_left,
  output logic [DATA_WIDTH-1:0] writedata_right,
  output logic                  clip_flag,
  output logic [15:0]           sample_count,
  output logic                  busy
);

  localparam int unsigned DW = DATA_WIDTH;
  localparam int unsigned SW = DATA_WIDTH + 1;
  localparam int unsigned PW = DATA_WIDTH + 9;

  localparam logic [DW-1:0] SEED_L_W = SEED_L[DW-1:0];
  localparam logic [DW-1:0] SEED_R_W = SEED_R[DW-1:0];
  localparam logic [DW-1:0] TAPS_L_W = TAPS_L[DW-1:0];
  localparam logic [DW-1:0] TAPS_R_W = TAPS_R[DW-1:0];

  localparam logic [4:0] SHIFT_MAX = 5'(DW - 1);

  localparam logic signed [DW-1:0] S_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic signed [DW-1:0] S_MIN = {1'b1, {(DW-1){1'b0}}};

  localparam logic [1:0] MODE_PASS = 2'b00;
  localparam logic [1:0] MODE_SWAP = 2'b01;
  localparam logic [1:0] MODE_MONO = 2'b10;
  localparam logic [1:0] MODE_MUTE = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ROUTE,
    ST_SCALE,
    ST_WRITE
  } state_t;

  state_t state;

  logic [DW-1:0]        lfsr_l, lfsr_r;
  logic signed [DW-1:0] in_l, in_r;
  logic signed [DW-1:0] noise_l_q, noise_r_q;
  logic signed [DW-1:0] mid_l, mid_r;
  logic [1:0]           mode_q;
  logic                 noise_en_q;
  logic [4:0]           shift_q;
  logic [7:0]           gain_q;

  logic signed [SW-1:0] mono_sum_c;
  logic signed [DW-1:0] mono_c;
  logic signed [DW-1:0] route_l_c, route_r_c;
  logic signed [DW-1:0] nz_l_c, nz_r_c;
  logic [DW:0]          mix_l_c, mix_r_c;
  logic signed [8:0]    gain_s_c;
  logic signed [PW-1:0] prod_l_c, prod_r_c;
  logic [DW:0]          scaled_l_c, scaled_r_c;
  logic                 clip_set_c;

  // Galois step; a zero state reloads the seed so the generator never locks up
  function automatic logic [DW-1:0] lfsr_step(input logic [DW-1:0] s,
                                               input logic [DW-1:0] seed,
                                               input logic [DW-1:0] taps);
    if (s == '0) return seed;
    return (s >> 1) ^ (s[0] ? taps : '0);
  endfunction

  // Narrow a DW+1 bit sum to DW bits; the result is {clipped, sample}
  function automatic logic [DW:0] sat_sum(input logic signed [SW-1:0] v);
    if (v[DW] != v[DW-1]) return {1'b1, (v[DW] ? S_MIN : S_MAX)};
    return {1'b0, v[DW-1:0]};
  endfunction

  // Narrow a shifted product to DW bits; the result is {clipped, sample}
  function automatic logic [DW:0] sat_prod(input logic signed [PW-1:0] v);
    if ((&v[PW-1:DW-1]) || !(|v[PW-1:DW-1])) return {1'b0, v[DW-1:0]};
    return {1'b1, (v[PW-1] ? S_MIN : S_MAX)};
  endfunction

  // Datapath: route + noise for the ROUTE state, gain for the SCALE state
  always_comb begin
    mono_sum_c = SW'(in_l) + SW'(in_r);
    mono_c     = DW'(mono_sum_c >>> 1);

    route_l_c = in_l;
    route_r_c = in_r;
    case (mode_q)
      MODE_PASS: begin
        route_l_c = in_l;
        route_r_c = in_r;
      end
      MODE_SWAP: begin
        route_l_c = in_r;
        route_r_c = in_l;
      end
      MODE_MONO: begin
        route_l_c = mono_c;
        route_r_c = mono_c;
      end
      MODE_MUTE: begin
        route_l_c = '0;
        route_r_c = '0;
      end
      default: ;
    endcase

    nz_l_c = '0;
    nz_r_c = '0;
    if (noise_en_q && (mode_q != MODE_MUTE)) begin
      nz_l_c = noise_l_q >>> shift_q;
      nz_r_c = noise_r_q >>> shift_q;
    end

    mix_l_c = sat_sum(SW'(route_l_c) + SW'(nz_l_c));
    mix_r_c = sat_sum(SW'(route_r_c) + SW'(nz_r_c));

    gain_s_c   = {1'b0, gain_q};
    prod_l_c   = PW'(mid_l) * PW'(gain_s_c);
    prod_r_c   = PW'(mid_r) * PW'(gain_s_c);
    scaled_l_c = sat_prod(prod_l_c >>> 4);
    scaled_r_c = sat_prod(prod_r_c >>> 4);

    clip_set_c = ((state == ST_ROUTE) && (mix_l_c[DW] || mix_r_c[DW])) ||
                 ((state == ST_SCALE) && (scaled_l_c[DW] || scaled_r_c[DW]));
  end

  // Sample FSM, LFSRs and all registered outputs
  always_ff @(posedge CLOCK2_50 or posedge reset) begin
    if (reset) begin
      state           <= ST_IDLE;
      lfsr_l          <= SEED_L_W;
      lfsr_r          <= SEED_R_W;
      in_l            <= '0;
      in_r            <= '0;
      noise_l_q       <= '0;
      noise_r_q       <= '0;
      mid_l           <= '0;
      mid_r           <= '0;
      mode_q          <= MODE_PASS;
      noise_en_q      <= 1'b0;
      shift_q         <= '0;
      gain_q          <= '0;
      read            <= 1'b0;
      write           <= 1'b0;
      writedata_left  <= '0;
      writedata_right <= '0;
      clip_flag       <= 1'b0;
      sample_count    <= '0;
      busy            <= 1'b0;
    end else begin
      read  <= 1'b0;
      write <= 1'b0;

      // A new clip in the same cycle as a clear keeps the flag set
      if (clip_set_c)    clip_flag <= 1'b1;
      else if (clip_clr) clip_flag <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (enable && read_ready && write_ready) begin
            in_l       <= readdata_left;
            in_r       <= readdata_right;
            mode_q     <= mode;
            noise_en_q <= noise_en;
            shift_q    <= (noise_shift > SHIFT_MAX) ? SHIFT_MAX : noise_shift;
            gain_q     <= gain;
            // Noise for this sample is the pre-advance LFSR value
            noise_l_q  <= lfsr_l;
            noise_r_q  <= lfsr_r;
            lfsr_l     <= lfsr_step(lfsr_l, SEED_L_W, TAPS_L_W);
            lfsr_r     <= lfsr_step(lfsr_r, SEED_R_W, TAPS_R_W);
            read       <= 1'b1;
            busy       <= 1'b1;
            state      <= ST_ROUTE;
          end
        end
        ST_ROUTE: begin
          mid_l <= mix_l_c[DW-1:0];
          mid_r <= mix_r_c[DW-1:0];
          state <= ST_SCALE;
        end
        ST_SCALE: begin
          writedata_left  <= scaled_l_c[DW-1:0];
          writedata_right <= scaled_r_c[DW-1:0];
          write           <= 1'b1;
          state           <= ST_WRITE;
        end
        ST_WRITE: begin
          sample_count <= sample_count + 16'd1;
          busy         <= 1'b0;
          state        <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_sample_processor.sv
// Testbench for audio_sample_processor: directed samples with literal expectations
// plus a sample-level reference model compared against every output on every cycle.
module tb_audio_sample_processor;

  localparam int unsigned DW = 24;
  localparam longint S_MAXV = 64'sd8388607;
  localparam longint S_MINV = -64'sd8388608;
  localparam logic [23:0] SEED_L = 24'h5AEC3D;
  localparam logic [23:0] SEED_R = 24'hC3197B;
  localparam logic [23:0] TAPS_L = 24'h0E0002;
  localparam logic [23:0] TAPS_R = 24'h0D0008;

  logic        CLOCK2_50      = 1'b0;
  logic        reset          = 1'b1;
  logic        enable         = 1'b0;
  logic [1:0]  mode           = 2'b00;
  logic        noise_en       = 1'b0;
  logic [4:0]  noise_shift    = 5'd0;
  logic [7:0]  gain           = 8'h10;
  logic        clip_clr       = 1'b0;
  logic        read_ready     = 1'b0;
  logic        write_ready    = 1'b0;
  logic [23:0] readdata_left  = 24'h0;
  logic [23:0] readdata_right = 24'h0;
  logic        read, write, clip_flag, busy;
  logic [23:0] writedata_left, writedata_right;
  logic [15:0] sample_count;

  int n_cmp = 0;
  int n_bad = 0;

  audio_sample_processor dut (
    .CLOCK2_50       (CLOCK2_50),
    .reset           (reset),
    .enable          (enable),
    .mode            (mode),
    .noise_en        (noise_en),
    .noise_shift     (noise_shift),
    .gain            (gain),
    .clip_clr        (clip_clr),
    .read_ready      (read_ready),
    .write_ready     (write_ready),
    .readdata_left   (readdata_left),
    .readdata_right  (readdata_right),
    .read            (read),
    .write           (write),
    .writedata_left  (writedata_left),
    .writedata_right (writedata_right),
    .clip_flag       (clip_flag),
    .sample_count    (sample_count),
    .busy            (busy)
  );

  always #10 CLOCK2_50 = ~CLOCK2_50;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic longint sx(input logic [23:0] v);
    return longint'($signed(v));
  endfunction

  function automatic longint clampv(input longint v, output bit c);
    c = 1'b0;
    if (v > S_MAXV) begin c = 1'b1; return S_MAXV; end
    if (v < S_MINV) begin c = 1'b1; return S_MINV; end
    return v;
  endfunction

  function automatic logic [23:0] lfsr_next(input logic [23:0] s, input logic [23:0] seed,
                                            input logic [23:0] taps);
    if (s == 24'h0) return seed;
    return (s >> 1) ^ (s[0] ? taps : 24'h0);
  endfunction

  // Whole-sample arithmetic: routing, noise, gain, with clip reported per stage
  function automatic void model_sample(input logic [1:0] md, input bit ne, input int sh,
                                       input int g, input logic [23:0] l, input logic [23:0] r,
                                       input logic [23:0] nl, input logic [23:0] nr,
                                       output logic [23:0] o_l, output logic [23:0] o_r,
                                       output bit c_route, output bit c_scale);
    longint a, b;
    bit ca, cb;
    int s;
    case (md)
      2'b00:   begin a = sx(l); b = sx(r); end
      2'b01:   begin a = sx(r); b = sx(l); end
      2'b10:   begin a = (sx(l) + sx(r)) >>> 1; b = a; end
      default: begin a = 0; b = 0; end
    endcase
    c_route = 1'b0;
    if (ne && md != 2'b11) begin
      s = (sh > 23) ? 23 : sh;
      a = clampv(a + (sx(nl) >>> s), ca);
      b = clampv(b + (sx(nr) >>> s), cb);
      c_route = ca | cb;
    end
    a = clampv((a * g) >>> 4, ca);
    b = clampv((b * g) >>> 4, cb);
    c_scale = ca | cb;
    o_l = a[23:0];
    o_r = b[23:0];
  endfunction

  int          m_phase;
  logic [23:0] m_lfsr_l, m_lfsr_r, m_pend_l, m_pend_r, m_wd_l, m_wd_r;
  bit          m_c1, m_c2, m_read, m_write, m_busy, m_clip;
  logic [15:0] m_cnt;

  always @(posedge CLOCK2_50 or posedge reset) begin : model
    logic [23:0] ol, orr;
    bit c1, c2, set;
    if (reset) begin
      m_phase <= 0; m_lfsr_l <= SEED_L; m_lfsr_r <= SEED_R;
      m_pend_l <= 0; m_pend_r <= 0; m_wd_l <= 0; m_wd_r <= 0;
      m_c1 <= 0; m_c2 <= 0; m_read <= 0; m_write <= 0; m_busy <= 0;
      m_clip <= 0; m_cnt <= 0;
    end else begin
      set = (m_phase == 1 && m_c1) || (m_phase == 2 && m_c2);
      m_clip  <= set ? 1'b1 : (clip_clr ? 1'b0 : m_clip);
      m_read  <= 1'b0;
      m_write <= (m_phase == 2);
      if (m_phase == 0) begin
        if (enable && read_ready && write_ready) begin
          model_sample(mode, noise_en, int'(noise_shift), int'(gain), readdata_left,
                       readdata_right, m_lfsr_l, m_lfsr_r, ol, orr, c1, c2);
          m_pend_l <= ol; m_pend_r <= orr; m_c1 <= c1; m_c2 <= c2;
          m_lfsr_l <= lfsr_next(m_lfsr_l, SEED_L, TAPS_L);
          m_lfsr_r <= lfsr_next(m_lfsr_r, SEED_R, TAPS_R);
          m_read <= 1'b1; m_busy <= 1'b1; m_phase <= 1;
        end
      end else if (m_phase == 2) begin
        m_wd_l <= m_pend_l; m_wd_r <= m_pend_r; m_phase <= 3;
      end else if (m_phase == 3) begin
        m_cnt <= m_cnt + 16'd1; m_busy <= 1'b0; m_phase <= 0;
      end else begin
        m_phase <= m_phase + 1;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge CLOCK2_50) begin
    if ($time > 15) begin
      check("read", read, m_read);
      check("write", write, m_write);
      check("busy", busy, m_busy);
      check("clip_flag", clip_flag, m_clip);
      check("sample_count", sample_count, m_cnt);
      check("writedata_left", writedata_left, m_wd_l);
      check("writedata_right", writedata_right, m_wd_r);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge CLOCK2_50);
    #1;
  endtask

  // One sample with literal expected outputs; scrambles controls after capture
  task automatic run(input string nm, input logic [1:0] md, input bit ne, input logic [4:0] sh,
                     input logic [7:0] g, input logic [23:0] l, input logic [23:0] r,
                     input logic [23:0] el, input logic [23:0] er, input bit eclip);
    int cyc;
    mode = md; noise_en = ne; noise_shift = sh; gain = g;
    readdata_left = l; readdata_right = r;
    enable = 1'b1; read_ready = 1'b1; write_ready = 1'b1;
    tick();
    check({nm, " read@k+1"}, read, 1'b1);
    enable = 1'b0; mode = ~md; gain = 8'hFF; noise_en = ~ne; noise_shift = ~sh;
    readdata_left = ~l; readdata_right = ~r;
    cyc = 0;
    while (!write && cyc < 10) begin
      tick();
      cyc++;
    end
    check({nm, " write latency"}, cyc, 2);
    check({nm, " out_l"}, writedata_left, el);
    check({nm, " out_r"}, writedata_right, er);
    check({nm, " clip"}, clip_flag, eclip);
    tick();
    check({nm, " idle after"}, busy, 1'b0);
  endtask

  initial begin
    repeat (2) tick();
    reset = 1'b0;
    tick();
    check("reset busy", busy, 1'b0);
    check("reset count", sample_count, 16'd0);
    check("reset out_l", writedata_left, 24'h0);

    run("pass", 2'b00, 1'b0, 5'd0, 8'h10, 24'h100000, 24'hF00000, 24'h100000, 24'hF00000, 1'b0);
    check("pass count", sample_count, 16'd1);
    run("swap", 2'b01, 1'b0, 5'd0, 8'h10, 24'h100000, 24'hF00000, 24'hF00000, 24'h100000, 1'b0);
    run("mono floor", 2'b10, 1'b0, 5'd0, 8'h10, 24'h000003, 24'h000000, 24'h000001, 24'h000001, 1'b0);
    run("mono neg", 2'b10, 1'b0, 5'd0, 8'h10, 24'h000000, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 1'b0);
    run("mono full", 2'b10, 1'b0, 5'd0, 8'h10, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF, 1'b0);
    run("gain x2 sat", 2'b00, 1'b0, 5'd0, 8'h20, 24'h400000, 24'h000000, 24'h7FFFFF, 24'h000000, 1'b1);

    clip_clr = 1'b1;
    tick();
    clip_clr = 1'b0;
    check("clip cleared", clip_flag, 1'b0);

    clip_clr = 1'b1;
    run("gain x3 neg sat", 2'b00, 1'b0, 5'd0, 8'h30, 24'h000000, 24'hC00000, 24'h000000, 24'h800000, 1'b1);
    tick();
    check("clip clr after", clip_flag, 1'b0);
    clip_clr = 1'b0;

    run("mute", 2'b11, 1'b1, 5'd0, 8'h10, 24'h123456, 24'h654321, 24'h000000, 24'h000000, 1'b0);
    run("gain half", 2'b00, 1'b0, 5'd0, 8'h08, 24'h000003, 24'hFFFFFD, 24'h000001, 24'hFFFFFE, 1'b0);
    run("gain zero", 2'b00, 1'b0, 5'd0, 8'h00, 24'h123456, 24'h800000, 24'h000000, 24'h000000, 1'b0);

    // DAC FIFO full: no capture even with data available
    enable = 1'b1; read_ready = 1'b1; write_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("no ready read", read, 1'b0);
      check("no ready busy", busy, 1'b0);
    end
    read_ready = 1'b0; write_ready = 1'b1;
    repeat (2) tick();

    // Back-to-back captures with enable held
    mode = 2'b10; gain = 8'h18; noise_en = 1'b1; noise_shift = 5'd31;
    readdata_left = 24'h234567; readdata_right = 24'hA00000;
    read_ready = 1'b1;
    repeat (8) tick();
    enable = 1'b0;
    repeat (5) tick();

    // Reset during SCALE aborts the sample
    mode = 2'b00; gain = 8'h10; noise_en = 1'b0;
    readdata_left = 24'h111111; readdata_right = 24'h222222;
    enable = 1'b1;
    tick();
    enable = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    check("abort out_l", writedata_left, 24'h0);
    check("abort busy", busy, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("abort no write", write, 1'b0);
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post abort write", write, 1'b0);
      check("post abort busy", busy, 1'b0);
    end

    // Noise from the seed value, then from the advanced LFSR with right-channel clip
    run("noise seed", 2'b00, 1'b1, 5'd4, 8'h10, 24'h000000, 24'h000000, 24'h05AEC3, 24'hFC3197, 1'b0);
    check("noise count", sample_count, 16'd1);
    run("noise step", 2'b00, 1'b1, 5'd20, 8'h10, 24'h000005, 24'h7FFFFF, 24'h000007, 24'h7FFFFF, 1'b1);
    run("noise clamp", 2'b00, 1'b1, 5'd31, 8'h10, 24'h000005, 24'h000009, 24'h000005, 24'h000009, 1'b1);

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
